fifo_level_buffer: RTL and testbench

Parametrised synchronous FIFO, the next generation of the UART-path FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Simultaneous read/write is defined at both the empty and the full boundary. It sits between the UART RX/TX engines and the host-side register interface.

---
 rtl/fifo_level_buffer.sv | 75 +++++++
 tb/tb_fifo_level_buffer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fifo_level_buffer.sv
// Synchronous first-word-fall-through FIFO with an occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_level_buffer #(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AF_LVL = 2**W - 2,
    parameter int AE_LVL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         r,
    input  logic         w,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   level,
    output logic         overflow,
    output logic         underflow
);
    localparam int         D     = 2**W;
    localparam logic [W:0] DEPTH = (W+1)'(D);
    localparam logic [W:0] AF    = (W+1)'(AF_LVL);
    localparam logic [W:0] AE    = (W+1)'(AE_LVL);

    logic [B-1:0] mem [D];
    logic [W-1:0] w_ptr, r_ptr;
    logic [W:0]   level_next;
    logic         flush, wr_ok, rd_ok;

    assign flush = rst | clr;
    // a full FIFO still accepts a write when a pop frees the slot in the same cycle
    assign wr_ok = w & (~full | r);
    assign rd_ok = r & ~empty;

    always_comb begin
        level_next = level;
        if (flush)
            level_next = '0;
        else if (wr_ok && !rd_ok)
            level_next = level + 1'b1;
        else if (rd_ok && !wr_ok)
            level_next = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) w_ptr <= w_ptr + 1'b1;
            if (rd_ok) r_ptr <= r_ptr + 1'b1;
            if (w && !wr_ok) overflow  <= 1'b1;
            if (r && !rd_ok) underflow <= 1'b1;
        end
        // flags track level_next so they never lag the count
        level        <= level_next;
        empty        <= (level_next == '0);
        full         <= (level_next == DEPTH);
        almost_empty <= (level_next <= AE);
        almost_full  <= (level_next >= AF);
    end

    always_ff @(posedge clk) begin
        if (!flush && wr_ok)
            mem[w_ptr] <= w_data;
    end

    assign r_data = mem[r_ptr];
endmodule

// File: tb/tb_fifo_level_buffer.sv
// Directed and randomized bench for fifo_level_buffer, scored against a queue model.
module tb_fifo_level_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b0, clr = 1'b0, r = 1'b0, w = 1'b0;
    logic [7:0] w_data = '0;

    logic [7:0] r_data_a, r_data_b;
    logic       empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
    logic       empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
    logic [4:0] level_a, level_b;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    bit         m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_level_buffer #(.B(8), .W(4)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .r(r), .w(w), .w_data(w_data),
        .r_data(r_data_a), .empty(empty_a), .full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .level(level_a),
        .overflow(ovf_a), .underflow(unf_a)
    );

    fifo_level_buffer #(.B(8), .W(4), .AF_LVL(16), .AE_LVL(0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .r(r), .w(w), .w_data(w_data),
        .r_data(r_data_b), .empty(empty_b), .full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .level(level_b),
        .overflow(ovf_b), .underflow(unf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        int n = q.size();
        chk("level",        32'(level_a), 32'(n));
        chk("empty",        32'(empty_a), 32'(n == 0));
        chk("full",         32'(full_a),  32'(n == 16));
        chk("almost_empty", 32'(ae_a),    32'(n <= 2));
        chk("almost_full",  32'(af_a),    32'(n >= 14));
        chk("overflow",     32'(ovf_a),   32'(m_ovf));
        chk("underflow",    32'(unf_a),   32'(m_unf));
        if (n > 0) chk("r_data", 32'(r_data_a), 32'(q[0]));
        chk("b_level",        32'(level_b), 32'(n));
        chk("b_almost_empty", 32'(ae_b),    32'(n == 0));
        chk("b_almost_full",  32'(af_b),    32'(n == 16));
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare.
    task automatic step(input bit i_rst, input bit i_clr, input bit i_w, input bit i_r,
                        input logic [7:0] d);
        bit acc_w, acc_r;
        rst = i_rst; clr = i_clr; w = i_w; r = i_r; w_data = d;
        @(posedge clk);
        if (i_rst || i_clr) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            acc_w = i_w && (q.size() < 16 || i_r);
            acc_r = i_r && q.size() > 0;
            if (acc_r) void'(q.pop_front());
            if (acc_w) q.push_back(d);
            if (i_w && !acc_w) m_ovf = 1;
            if (i_r && !acc_r) m_unf = 1;
        end
        #1;
        compare_all();
    endtask

    initial begin
        // reset with both requests active: nothing may move
        step(1, 0, 1, 1, 8'hEE);
        chk("reset_level", 32'(level_a), 32'd0);
        step(0, 0, 0, 0, 8'h00);

        // fill 0x00..0x0F, then one rejected write
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 8'(i));
        chk("filled_full", 32'(full_a), 32'd1);
        step(0, 0, 1, 0, 8'hAA);
        chk("ovf_set", 32'(ovf_a), 32'd1);

        // full boundary simultaneous r/w: 0x55 goes in last, no overflow change
        step(0, 0, 1, 1, 8'h55);
        chk("full_rw_level", 32'(level_a), 32'd16);

        // drain everything
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'h00);
        chk("drained_empty", 32'(empty_a), 32'd1);

        // underflow on empty
        step(0, 0, 0, 1, 8'h00);
        chk("unf_set", 32'(unf_a), 32'd1);

        // empty boundary simultaneous r/w: write accepted, read rejected
        step(0, 0, 1, 1, 8'h33);
        chk("empty_rw_data", 32'(r_data_a), 32'h33);
        chk("empty_rw_level", 32'(level_a), 32'd1);

        // flush clears flags and contents
        step(0, 1, 0, 0, 8'h00);
        chk("clr_ovf", 32'(ovf_a), 32'd0);

        // random traffic with level held in 3..13, wrapping pointers several times
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'($urandom));
        for (int i = 0; i < 80; i++) begin
            bit rw, rr;
            rw = 1;
            rr = bit'($urandom_range(0, 1));
            if (q.size() >= 13) begin rw = 0; rr = 1; end
            else if (q.size() <= 3) begin rw = 1; rr = 0; end
            step(0, 0, rw, rr, 8'($urandom));
        end

        // flush mid-stream with a concurrent write, then a fresh push
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 8'(8'h40 + i));
        chk("pre_flush_level", 32'(level_a), 32'd7);
        step(0, 1, 1, 0, 8'hDD);
        chk("flush_empty", 32'(empty_a), 32'd1);
        step(0, 0, 1, 0, 8'h9C);
        chk("post_flush_data", 32'(r_data_a), 32'h9C);

        // fill the second instance's thresholds to the exact boundary
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 8'($urandom));
        chk("b_af_full", 32'(af_b), 32'(full_b));
        step(0, 0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
